trace_alloc: RTL and testbench
==============================

TRACE_ALLOC -- requirements
Module: trace_alloc

Interface
REQ-001 Parameter NUM_TRACE_LINES, default 64; number of trace cache lines managed.
REQ-002 Parameter AGE_PERIOD, default 8; cycles between periodic age ticks.
REQ-003 Parameter STARVE_LIMIT, default 16; consecutive no-free-line cycles before a forced age.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port invalidate  input  1  clear all line usage state (trace cache invalidate).
REQ-007 Port hit_vec  input  NUM_TRACE_LINES  one-hot lookup match vector.
REQ-008 Port pc_used  input  1  fetch consumed the hit line this cycle.
REQ-009 Port alloc_take  input  1  cache writes a new row into the offered slot this cycle.
REQ-010 Port update_valid  input  1  cache extends an existing row this cycle.
REQ-011 Port update_line  input  clog2(NUM_TRACE_LINES)  index of the row being extended.
REQ-012 Port next_use  output  NUM_TRACE_LINES  one-hot offered free slot.
REQ-013 Port next_use_idx  output  clog2(NUM_TRACE_LINES)  encoded index of next_use.
REQ-014 Port next_use_valid  output  1  an offered free slot exists.
REQ-015 Port free_count  output  clog2(NUM_TRACE_LINES)+1  number of lines with use count 0.
REQ-016 Port age_tick  output  1  an age decrement (periodic or forced) is applied this cycle.

Function
REQ-017 Each line holds a 3-bit saturating use counter; a line is free when its counter is 0.
REQ-018 Age counter: 3-bit down-counter reloading AGE_PERIOD-1 when it reaches 0; periodic tick asserted in the cycle the counter is 0.
REQ-019 Starve counter: increments each cycle next_use_valid=0; clears when next_use_valid=1; force tick asserted when it equals STARVE_LIMIT-1, after which it clears.
REQ-020 age_tick = periodic tick OR force tick, combinational from registered state.
REQ-021 Per-line update priority, highest first: invalidate -> counter 0; allocation/update write -> counter raised to 2 if below 2, else unchanged; hit (pc_used and hit_vec bit) -> +1 saturating at 7, suppressed when age_tick=1; age_tick -> -1 if nonzero; otherwise hold.
REQ-022 Allocation write targets the line in next_use when alloc_take=1 and next_use_valid=1; alloc_take with next_use_valid=0 is ignored.
REQ-023 Update write targets update_line when update_valid=1; alloc_take and update_valid in the same cycle apply to both lines; same line -> single raise to 2.
REQ-024 A hit on a line being written in the same cycle takes the write rule only.
REQ-025 next_use, next_use_idx, next_use_valid, free_count are registered, computed from next-state counters: 1-cycle latency from any counter change.
REQ-026 next_use selects the lowest-index free line; none free -> next_use=0, next_use_idx=0, next_use_valid=0.
REQ-027 A taken slot is never offered in the following cycle (its counter becomes 2).
REQ-028 invalidate concurrent with alloc_take/update_valid: invalidate wins; next cycle next_use=line 0, free_count=NUM_TRACE_LINES; age and starve counters are not affected.

Reset
REQ-029 On reset assertion, asynchronously: all use counters 0, age counter AGE_PERIOD-1, starve counter 0.
REQ-030 Output reset values: next_use=1 (line 0), next_use_idx=0, next_use_valid=1, free_count=NUM_TRACE_LINES, age_tick=0.
REQ-031 Reset mid-operation discards all pending writes and hits in that cycle; first post-release edge follows REQ-021 from the reset state.

Verification
REQ-032 Release reset, alloc_take each cycle for 3 cycles -> next_use offers lines 0,1,2 then 3; free_count 64,63,62,61.
REQ-033 Allocate line 0, hold pc_used with hit_vec=1 for 10 cycles -> line 0 counter saturates at 7, no increment on age_tick cycles, never offered.
REQ-034 Allocate all 64 lines, no hits -> next_use_valid=0; age ticks drive counters to 0 within 16 cycles; next_use_valid returns with next_use=line 0.
REQ-035 Pin all lines at 7 by continuous hits with next_use_valid=0 -> force age_tick every 16th starved cycle, each hit-pinned line still decremented on that cycle.
REQ-036 alloc_take, update_valid (update_line=5) and invalidate same cycle -> next cycle all counters 0, next_use=line 0, free_count=64.
REQ-037 Assert reset for 1 cycle mid-sequence with 10 lines allocated -> outputs immediately return to REQ-030 values without waiting for clk.

Source files
------------

// File: rtl/trace_alloc_if.sv
// Bus between the trace cache and its line allocator: lookup/write activity in,
// offered free slot, occupancy and age tick out.
interface trace_alloc_if #(
   parameter int NUM_TRACE_LINES = 64
) ();
   localparam int IDX_W = (NUM_TRACE_LINES > 1) ? $clog2(NUM_TRACE_LINES) : 1;
   localparam int CNT_W = $clog2(NUM_TRACE_LINES) + 1;

   logic                       invalidate;
   logic [NUM_TRACE_LINES-1:0] hit_vec;
   logic                       pc_used;
   logic                       alloc_take;
   logic                       update_valid;
   logic [IDX_W-1:0]           update_line;
   logic [NUM_TRACE_LINES-1:0] next_use;
   logic [IDX_W-1:0]           next_use_idx;
   logic                       next_use_valid;
   logic [CNT_W-1:0]           free_count;
   logic                       age_tick;

   modport master (
      output invalidate, hit_vec, pc_used, alloc_take, update_valid, update_line,
      input  next_use, next_use_idx, next_use_valid, free_count, age_tick
   );

   modport slave (
      input  invalidate, hit_vec, pc_used, alloc_take, update_valid, update_line,
      output next_use, next_use_idx, next_use_valid, free_count, age_tick
   );
endinterface

// File: rtl/trace_alloc.sv
// Trace cache line allocator: per-line 3-bit use counters with periodic and
// starvation-forced aging, offering the lowest-index free line for the next fill.
module trace_alloc #(
   parameter int NUM_TRACE_LINES = 64,
   parameter int AGE_PERIOD      = 8,
   parameter int STARVE_LIMIT    = 16
) (
   input logic          clk,
   input logic          reset,
   trace_alloc_if.slave bus
);
   localparam int IDX_W  = (NUM_TRACE_LINES > 1) ? $clog2(NUM_TRACE_LINES) : 1;
   localparam int CNT_W  = $clog2(NUM_TRACE_LINES) + 1;
   localparam int AGE_W  = 3;
   localparam int ST_W   = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

   localparam logic [AGE_W-1:0] AGE_RELOAD = AGE_W'(AGE_PERIOD - 1);
   localparam logic [ST_W-1:0]  STARVE_TC  = ST_W'(STARVE_LIMIT - 1);
   localparam logic [2:0]       USE_FILL   = 3'd2;
   localparam logic [2:0]       USE_MAX    = 3'd7;

   logic [2:0]                 use_q [NUM_TRACE_LINES];
   logic [2:0]                 use_d [NUM_TRACE_LINES];
   logic [AGE_W-1:0]           age_q, age_d;
   logic [ST_W-1:0]            starve_q, starve_d;
   logic [NUM_TRACE_LINES-1:0] next_use_q, next_use_d;
   logic [IDX_W-1:0]           next_use_idx_q, next_use_idx_d;
   logic                       next_use_valid_q, next_use_valid_d;
   logic [CNT_W-1:0]           free_count_q, free_count_d;

   logic age_tick;
   logic periodic_tick;
   logic force_tick;

   always_comb begin
      periodic_tick = (age_q == '0);
      force_tick    = (starve_q == STARVE_TC);
      age_tick      = periodic_tick || force_tick;

      age_d = periodic_tick ? AGE_RELOAD : age_q - AGE_W'(1);

      if (next_use_valid_q || force_tick) begin
         starve_d = '0;
      end else begin
         starve_d = starve_q + ST_W'(1);
      end
   end

   // Write beats hit, hit beats age; a hit is dropped entirely on an age cycle
   // so pinned lines still drain when the cache is starved.
   always_comb begin
      for (int i = 0; i < NUM_TRACE_LINES; i++) begin
         logic wr;
         logic hit;
         wr  = (bus.alloc_take && next_use_valid_q && next_use_q[i]) ||
               (bus.update_valid && (bus.update_line == IDX_W'(i)));
         hit = bus.pc_used && bus.hit_vec[i] && !age_tick;

         use_d[i] = use_q[i];
         if (bus.invalidate) begin
            use_d[i] = '0;
         end else if (wr) begin
            if (use_q[i] < USE_FILL) begin
               use_d[i] = USE_FILL;
            end
         end else if (hit) begin
            if (use_q[i] != USE_MAX) begin
               use_d[i] = use_q[i] + 3'd1;
            end
         end else if (age_tick && (use_q[i] != '0)) begin
            use_d[i] = use_q[i] - 3'd1;
         end
      end
   end

   // Scan from the top so the last assignment leaves the lowest free index.
   always_comb begin
      next_use_d       = '0;
      next_use_idx_d   = '0;
      next_use_valid_d = 1'b0;
      free_count_d     = '0;
      for (int i = NUM_TRACE_LINES - 1; i >= 0; i--) begin
         if (use_d[i] == '0) begin
            free_count_d     = free_count_d + CNT_W'(1);
            next_use_idx_d   = IDX_W'(i);
            next_use_valid_d = 1'b1;
         end
      end
      if (next_use_valid_d) begin
         next_use_d[next_use_idx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_TRACE_LINES; i++) begin
            use_q[i] <= '0;
         end
         age_q            <= AGE_RELOAD;
         starve_q         <= '0;
         next_use_q       <= NUM_TRACE_LINES'(1);
         next_use_idx_q   <= '0;
         next_use_valid_q <= 1'b1;
         free_count_q     <= CNT_W'(NUM_TRACE_LINES);
      end else begin
         for (int i = 0; i < NUM_TRACE_LINES; i++) begin
            use_q[i] <= use_d[i];
         end
         age_q            <= age_d;
         starve_q         <= starve_d;
         next_use_q       <= next_use_d;
         next_use_idx_q   <= next_use_idx_d;
         next_use_valid_q <= next_use_valid_d;
         free_count_q     <= free_count_d;
      end
   end

   assign bus.next_use       = next_use_q;
   assign bus.next_use_idx   = next_use_idx_q;
   assign bus.next_use_valid = next_use_valid_q;
   assign bus.free_count     = free_count_q;
   assign bus.age_tick       = age_tick;
endmodule

// File: tb/tb_trace_alloc.sv
// Directed bench for trace_alloc: a 64-line instance for allocation, hit and
// invalidate behaviour, and a 2-line instance that can be driven into starvation.
module tb_trace_alloc;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   trace_alloc_if #(.NUM_TRACE_LINES(64)) ifd ();
   trace_alloc_if #(.NUM_TRACE_LINES(2))  ifs ();

   trace_alloc #(.NUM_TRACE_LINES(64), .AGE_PERIOD(8), .STARVE_LIMIT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifd)
   );

   trace_alloc #(.NUM_TRACE_LINES(2), .AGE_PERIOD(8), .STARVE_LIMIT(16)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ifd.invalidate = 1'b0; ifd.hit_vec = '0; ifd.pc_used = 1'b0;
      ifd.alloc_take = 1'b0; ifd.update_valid = 1'b0; ifd.update_line = '0;
      ifs.invalidate = 1'b0; ifs.hit_vec = '0; ifs.pc_used = 1'b0;
      ifs.alloc_take = 1'b0; ifs.update_valid = 1'b0; ifs.update_line = '0;
   endtask

   initial begin
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      chk("rst_next_use", ifd.next_use, 64'd1);
      chk("rst_idx", 64'(ifd.next_use_idx), 64'd0);
      chk("rst_valid", 64'(ifd.next_use_valid), 64'd1);
      chk("rst_free", 64'(ifd.free_count), 64'd64);
      chk("rst_age_tick", 64'(ifd.age_tick), 64'd0);
      chk("rst_s_free", 64'(ifs.free_count), 64'd2);
      reset = 1'b1;

      // Back-to-back allocation (edges E1..E3 after release)
      ifd.alloc_take = 1'b1;
      tick();
      chk("alloc1_idx", 64'(ifd.next_use_idx), 64'd1);
      chk("alloc1_next_use", ifd.next_use, 64'h2);
      chk("alloc1_free", 64'(ifd.free_count), 64'd63);
      tick();
      chk("alloc2_idx", 64'(ifd.next_use_idx), 64'd2);
      chk("alloc2_free", 64'(ifd.free_count), 64'd62);
      tick();
      chk("alloc3_next_use", ifd.next_use, 64'h8);
      chk("alloc3_free", 64'(ifd.free_count), 64'd61);
      ifd.alloc_take = 1'b0;

      // Periodic aging: tick visible after E7, applied on E8 and E16
      repeat (3) tick();
      chk("age_e6", 64'(ifd.age_tick), 64'd0);
      tick();
      chk("age_e7", 64'(ifd.age_tick), 64'd1);
      tick();
      chk("age_e8_tick", 64'(ifd.age_tick), 64'd0);
      chk("age_e8_free", 64'(ifd.free_count), 64'd61);
      chk("age_e8_idx", 64'(ifd.next_use_idx), 64'd3);
      repeat (7) tick();
      chk("age_e15", 64'(ifd.age_tick), 64'd1);
      tick();
      chk("age_e16_free", 64'(ifd.free_count), 64'd64);
      chk("age_e16_idx", 64'(ifd.next_use_idx), 64'd0);

      // Allocate line 0 then hold hits on it (E17..E27)
      ifd.alloc_take = 1'b1;
      tick();
      chk("hit_alloc_idx", 64'(ifd.next_use_idx), 64'd1);
      ifd.alloc_take = 1'b0;
      ifd.pc_used    = 1'b1;
      ifd.hit_vec    = 64'd1;
      for (int k = 18; k <= 27; k++) begin
         tick();
         chk("hit_free", 64'(ifd.free_count), 64'd63);
         chk("hit_idx", 64'(ifd.next_use_idx), 64'd1);
         chk("hit_age_tick", 64'(ifd.age_tick), (k == 23) ? 64'd1 : 64'd0);
      end
      ifd.pc_used = 1'b0;
      ifd.hit_vec = '0;

      // Invalidate with concurrent alloc and update (E28)
      ifd.invalidate   = 1'b1;
      ifd.alloc_take   = 1'b1;
      ifd.update_valid = 1'b1;
      ifd.update_line  = 6'd5;
      tick();
      chk("inv_free", 64'(ifd.free_count), 64'd64);
      chk("inv_next_use", ifd.next_use, 64'd1);
      chk("inv_valid", 64'(ifd.next_use_valid), 64'd1);
      ifd.invalidate = 1'b0;

      // E29: alloc and update hit the same line; E30: different lines
      ifd.update_line = 6'd0;
      ifs.alloc_take  = 1'b1;
      tick();
      chk("same_line_free", 64'(ifd.free_count), 64'd63);
      chk("same_line_idx", 64'(ifd.next_use_idx), 64'd1);
      chk("s_alloc1_free", 64'(ifs.free_count), 64'd1);
      chk("s_alloc1_idx", 64'(ifs.next_use_idx), 64'd1);
      ifd.update_line = 6'd3;
      tick();
      chk("two_line_free", 64'(ifd.free_count), 64'd61);
      chk("two_line_idx", 64'(ifd.next_use_idx), 64'd2);
      chk("s_full_valid", 64'(ifs.next_use_valid), 64'd0);
      chk("s_full_next_use", 64'(ifs.next_use), 64'd0);
      chk("s_full_free", 64'(ifs.free_count), 64'd0);
      clear_inputs();

      // Full small cache drains by aging alone (E32, E40)
      repeat (9) tick();
      chk("s_drain_e39", 64'(ifs.next_use_valid), 64'd0);
      tick();
      chk("s_drain_valid", 64'(ifs.next_use_valid), 64'd1);
      chk("s_drain_free", 64'(ifs.free_count), 64'd2);
      chk("s_drain_next_use", 64'(ifs.next_use), 64'd1);
      chk("d_drain_free", 64'(ifd.free_count), 64'd64);

      // Fill small cache (E41, E42) then alternate hits L0/L1 (E43..E74)
      ifs.alloc_take = 1'b1;
      tick();
      tick();
      chk("s_fill_valid", 64'(ifs.next_use_valid), 64'd0);
      ifs.alloc_take = 1'b0;
      ifs.pc_used    = 1'b1;
      for (int k = 43; k <= 74; k++) begin
         ifs.hit_vec = (k % 2 == 1) ? 2'b01 : 2'b10;
         tick();
         chk("starve_valid", 64'(ifs.next_use_valid), 64'd0);
         chk("starve_age_tick", 64'(ifs.age_tick),
             ((k % 8 == 7) || (k == 57) || (k == 73)) ? 64'd1 : 64'd0);
      end
      ifs.pc_used = 1'b0;
      ifs.hit_vec = '0;

      // Lines left at (6,5); drain with periodic and forced ticks (E75..E104)
      for (int k = 75; k <= 103; k++) begin
         tick();
         chk("drain_valid", 64'(ifs.next_use_valid), 64'd0);
         chk("drain_age_tick", 64'(ifs.age_tick),
             ((k % 8 == 7) || (k == 89)) ? 64'd1 : 64'd0);
      end
      tick();
      chk("drain_e104_free", 64'(ifs.free_count), 64'd1);
      chk("drain_e104_idx", 64'(ifs.next_use_idx), 64'd1);
      chk("drain_e104_next_use", 64'(ifs.next_use), 64'd2);

      // Ten allocations (E105..E114), then asynchronous reset mid-cycle
      ifd.alloc_take = 1'b1;
      repeat (10) tick();
      ifd.alloc_take = 1'b0;
      chk("ten_free", 64'(ifd.free_count), 64'd54);
      chk("ten_idx", 64'(ifd.next_use_idx), 64'd10);
      repeat (5) tick();
      chk("ten_e119_age", 64'(ifd.age_tick), 64'd1);
      chk("ten_e119_free", 64'(ifd.free_count), 64'd54);
      #2;
      reset = 1'b0;
      #1;
      chk("async_next_use", ifd.next_use, 64'd1);
      chk("async_idx", 64'(ifd.next_use_idx), 64'd0);
      chk("async_valid", 64'(ifd.next_use_valid), 64'd1);
      chk("async_free", 64'(ifd.free_count), 64'd64);
      chk("async_age_tick", 64'(ifd.age_tick), 64'd0);
      chk("async_s_free", 64'(ifs.free_count), 64'd2);
      tick();
      reset = 1'b1;
      ifd.alloc_take = 1'b1;
      tick();
      ifd.alloc_take = 1'b0;
      chk("post_rst_idx", 64'(ifd.next_use_idx), 64'd1);
      chk("post_rst_free", 64'(ifd.free_count), 64'd63);
      chk("post_rst_age0", 64'(ifd.age_tick), 64'd0);
      repeat (6) tick();
      chk("post_rst_age7", 64'(ifd.age_tick), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
